// File: rtl/uart_bus_master_if.sv
// Signal bundle between the UART byte stream, the memory bus and the bus master.
// The master modport is the initiator's view; slave is the environment's view.
interface uart_bus_master_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        mem_valid;
  logic        mem_instr;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        overrun;

  modport master (
    input  rx_data, rx_valid, tx_ready, mem_ready, mem_rdata,
    output tx_data, tx_valid, mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
           busy, overrun
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, mem_ready, mem_rdata,
    input  tx_data, tx_valid, mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
           busy, overrun
  );
endinterface

// File: rtl/uart_bus_master.sv
// Serial command decoder that issues single-word reads/writes on the memory bus
// and answers over the byte transmitter ('K', read data, 'T' timeout, '?' unknown).
module uart_bus_master #(
  parameter int TIMEOUT = 256
) (
  input logic               clk_i,
  input logic               rst_i,
  uart_bus_master_if.master bus
);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [7:0] CMD_WR = 8'h57;
  localparam logic [7:0] CMD_RD = 8'h52;

  typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;

  state_t        state, state_nxt;
  logic          is_wr;
  logic [1:0]    byte_cnt;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   resp_q;
  logic [2:0]    resp_left;
  logic [TW-1:0] tmo_cnt;
  logic          overrun_q;
  logic          mem_valid_c, tx_valid_c, busy_c;

  logic rx_is_cmd, bus_done, bus_tmo, tx_fire;
  assign rx_is_cmd = (bus.rx_data == CMD_WR) || (bus.rx_data == CMD_RD);
  assign bus_done  = (state == BUS) && bus.mem_ready;
  assign bus_tmo   = (state == BUS) && !bus.mem_ready && (tmo_cnt == TMO_LAST);
  assign tx_fire   = (state == RESP) && bus.tx_ready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.rx_valid) state_nxt = rx_is_cmd ? ADDR : RESP;
      ADDR: if (bus.rx_valid && byte_cnt == 2'd3) state_nxt = is_wr ? DATA : BUS;
      DATA: if (bus.rx_valid && byte_cnt == 2'd3) state_nxt = BUS;
      BUS:  if (bus_done || bus_tmo) state_nxt = RESP;
      RESP: if (tx_fire && resp_left == 3'd1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_valid_c = 1'b0;
    tx_valid_c  = 1'b0;
    busy_c      = 1'b1;
    case (state)
      IDLE:    busy_c      = 1'b0;
      BUS:     mem_valid_c = 1'b1;
      RESP:    tx_valid_c  = 1'b1;
      default: ;
    endcase
  end

  // Byte collection, bus timeout and response shift register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      is_wr     <= 1'b0;
      byte_cnt  <= 2'd0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      resp_q    <= 32'h0;
      resp_left <= 3'd0;
      tmo_cnt   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (state == IDLE) byte_cnt <= 2'd0;
      else if ((state == ADDR || state == DATA) && bus.rx_valid) byte_cnt <= byte_cnt + 2'd1;

      if (state == IDLE && bus.rx_valid) is_wr <= (bus.rx_data == CMD_WR);
      if (state == ADDR && bus.rx_valid) addr_q  <= {addr_q[23:0], bus.rx_data};
      if (state == DATA && bus.rx_valid) wdata_q <= {wdata_q[23:0], bus.rx_data};

      // Counter sits at zero outside BUS, so it is already cleared on entry
      if (state != BUS)         tmo_cnt <= '0;
      else if (!bus.mem_ready)  tmo_cnt <= tmo_cnt + 1'b1;

      if (state == IDLE && bus.rx_valid && !rx_is_cmd) begin
        resp_q    <= {8'h3F, 24'h0};
        resp_left <= 3'd1;
      end else if (bus_done) begin
        resp_q    <= is_wr ? {8'h4B, 24'h0} : bus.mem_rdata;
        resp_left <= is_wr ? 3'd1 : 3'd4;
      end else if (bus_tmo) begin
        resp_q    <= {8'h54, 24'h0};
        resp_left <= 3'd1;
      end else if (tx_fire) begin
        resp_q    <= {resp_q[23:0], 8'h0};
        resp_left <= resp_left - 3'd1;
      end

      if ((state == BUS || state == RESP) && bus.rx_valid) overrun_q <= 1'b1;
    end
  end

  assign bus.mem_valid = mem_valid_c;
  assign bus.mem_instr = 1'b0;
  assign bus.mem_addr  = {addr_q[31:2], 2'b00};
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wstrb = (mem_valid_c && is_wr) ? 4'hF : 4'h0;
  assign bus.tx_valid  = tx_valid_c;
  assign bus.tx_data   = resp_q[31:24];
  assign bus.busy      = busy_c;
  assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_uart_bus_master.sv
// Bench for uart_bus_master: vector table of commands plus hand-written overrun,
// late-ready and mid-transaction reset sequences, with bus and tx scoreboards.
module tb_uart_bus_master;
  logic clk   = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk = ~clk;

  uart_bus_master_if bus ();
  uart_bus_master #(.TIMEOUT(256)) dut (.clk_i(clk), .rst_i(rst_i), .bus(bus));

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    int          ready_at;
    int          vlen;
  } bus_exp_t;

  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ready_at;
    bit          throttle;
    bit          has_bus;
    logic [31:0] exp_addr;
    logic [3:0]  exp_wstrb;
    int          exp_vlen;
    int          exp_ntx;
    logic [31:0] exp_tx;
  } vec_t;

  bus_exp_t   bus_q[$];
  logic [7:0] tx_q[$];
  int checks = 0;
  int errors = 0;
  bit throttle = 1'b0;
  bit late_pulse = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Memory responder: checks each request and raises ready on the configured cycle
  initial begin : responder
    bus_exp_t cur;
    int vcnt;
    vcnt = 0;
    cur = '{addr: 32'h0, wdata: 32'h0, wstrb: 4'h0, rdata: 32'h0, ready_at: -1, vlen: 0};
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (bus.mem_valid) begin
        if (vcnt == 0) begin
          if (bus_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL bus_unexpected actual=req@%h required=no request", bus.mem_addr);
            cur = '{addr: bus.mem_addr, wdata: bus.mem_wdata, wstrb: bus.mem_wstrb,
                    rdata: 32'h0, ready_at: 0, vlen: 0};
          end else begin
            cur = bus_q.pop_front();
          end
        end
        chk("mem_addr", bus.mem_addr, cur.addr);
        chk("mem_wstrb", 32'(bus.mem_wstrb), 32'(cur.wstrb));
        if (cur.wstrb == 4'hF) chk("mem_wdata", bus.mem_wdata, cur.wdata);
        chk("mem_instr", 32'(bus.mem_instr), 32'h0);
        bus.mem_ready = (vcnt == cur.ready_at);
        bus.mem_rdata = bus.mem_ready ? cur.rdata : ~cur.rdata;
        vcnt++;
      end else begin
        if (vcnt > 0 && cur.vlen > 0) chk("valid_cycles", vcnt, cur.vlen);
        vcnt = 0;
        bus.mem_ready = late_pulse;
        bus.mem_rdata = 32'h0;
      end
    end
  end

  // Transmit sink: optional ready throttling, hold check, byte scoreboard
  initial begin : tx_mon
    bit hold;
    logic [7:0] held;
    logic [7:0] e;
    hold = 1'b0;
    held = 8'h0;
    bus.tx_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (hold && bus.tx_valid) chk("tx_hold", 32'(bus.tx_data), 32'(held));
      bus.tx_ready = throttle ? ~bus.tx_ready : 1'b1;
      if (bus.tx_valid && bus.tx_ready) begin
        if (tx_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected actual=%h required=no byte", bus.tx_data);
        end else begin
          e = tx_q.pop_front();
          chk("tx_byte", 32'(bus.tx_data), 32'(e));
        end
      end
      hold = bus.tx_valid && !bus.tx_ready;
      held = bus.tx_data;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] wdata);
    send_byte(cmd);
    chk("busy_after_cmd", 32'(bus.busy), 32'h1);
    if (cmd == 8'h57 || cmd == 8'h52)
      for (int k = 0; k < 4; k++) send_byte(addr[31-8*k -: 8]);
    if (cmd == 8'h57)
      for (int k = 0; k < 4; k++) send_byte(wdata[31-8*k -: 8]);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((bus.busy || bus.tx_valid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.busy || bus.tx_valid) begin
      errors++;
      $display("FAIL %s_idle actual=busy required=idle within 400 cycles", name);
    end
  endtask

  task automatic check_drained(input string name);
    chk({name, "_bus_q"}, 32'(bus_q.size()), 32'h0);
    chk({name, "_tx_q"}, 32'(tx_q.size()), 32'h0);
  endtask

  task automatic push_tx(input int n, input logic [31:0] bytes);
    for (int k = 0; k < n; k++) tx_q.push_back(bytes[31-8*k -: 8]);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mem_valid"}, 32'(bus.mem_valid), 32'h0);
    chk({tag, "_mem_addr"},  bus.mem_addr, 32'h0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'h0);
    chk({tag, "_mem_wstrb"}, 32'(bus.mem_wstrb), 32'h0);
    chk({tag, "_mem_instr"}, 32'(bus.mem_instr), 32'h0);
    chk({tag, "_tx_valid"},  32'(bus.tx_valid), 32'h0);
    chk({tag, "_tx_data"},   32'(bus.tx_data), 32'h0);
    chk({tag, "_busy"},      32'(bus.busy), 32'h0);
    chk({tag, "_overrun"},   32'(bus.overrun), 32'h0);
  endtask

  initial begin : main
    vec_t vecs[6];
    vec_t v;
    int   n;

    vecs[0] = '{cmd: 8'h57, addr: 32'h0000_0100, wdata: 32'hDEAD_BEEF, rdata: 32'h0,
                ready_at: 2, throttle: 1'b0, has_bus: 1'b1, exp_addr: 32'h0000_0100,
                exp_wstrb: 4'hF, exp_vlen: 3, exp_ntx: 1, exp_tx: 32'h4B00_0000};
    vecs[1] = '{cmd: 8'h52, addr: 32'h0000_0100, wdata: 32'h0, rdata: 32'h1234_5678,
                ready_at: 0, throttle: 1'b1, has_bus: 1'b1, exp_addr: 32'h0000_0100,
                exp_wstrb: 4'h0, exp_vlen: 1, exp_ntx: 4, exp_tx: 32'h1234_5678};
    vecs[2] = '{cmd: 8'h57, addr: 32'h0000_0103, wdata: 32'h0BAD_F00D, rdata: 32'h0,
                ready_at: 1, throttle: 1'b0, has_bus: 1'b1, exp_addr: 32'h0000_0100,
                exp_wstrb: 4'hF, exp_vlen: 2, exp_ntx: 1, exp_tx: 32'h4B00_0000};
    vecs[3] = '{cmd: 8'h41, addr: 32'h0, wdata: 32'h0, rdata: 32'h0,
                ready_at: 0, throttle: 1'b0, has_bus: 1'b0, exp_addr: 32'h0,
                exp_wstrb: 4'h0, exp_vlen: 0, exp_ntx: 1, exp_tx: 32'h3F00_0000};
    vecs[4] = '{cmd: 8'h52, addr: 32'h0000_0206, wdata: 32'h0, rdata: 32'hA5A5_5A5A,
                ready_at: 4, throttle: 1'b1, has_bus: 1'b1, exp_addr: 32'h0000_0204,
                exp_wstrb: 4'h0, exp_vlen: 5, exp_ntx: 4, exp_tx: 32'hA5A5_5A5A};
    vecs[5] = '{cmd: 8'h52, addr: 32'hFFFF_FFFF, wdata: 32'h0, rdata: 32'h0,
                ready_at: -1, throttle: 1'b0, has_bus: 1'b1, exp_addr: 32'hFFFF_FFFC,
                exp_wstrb: 4'h0, exp_vlen: 256, exp_ntx: 1, exp_tx: 32'h5400_0000};

    bus.rx_data  = 8'h0;
    bus.rx_valid = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      throttle = v.throttle;
      if (v.has_bus)
        bus_q.push_back('{addr: v.exp_addr, wdata: v.wdata, wstrb: v.exp_wstrb,
                          rdata: v.rdata, ready_at: v.ready_at, vlen: v.exp_vlen});
      push_tx(v.exp_ntx, v.exp_tx);
      send_cmd(v.cmd, v.addr, v.wdata);
      wait_idle($sformatf("vec%0d", i));
      check_drained($sformatf("vec%0d", i));
    end
    throttle = 1'b0;

    // A ready pulse with no request outstanding must not start anything
    late_pulse = 1'b1;
    repeat (3) @(negedge clk);
    late_pulse = 1'b0;
    repeat (2) @(negedge clk);
    chk("late_ready_mem_valid", 32'(bus.mem_valid), 32'h0);
    chk("late_ready_busy", 32'(bus.busy), 32'h0);
    chk("late_ready_tx_valid", 32'(bus.tx_valid), 32'h0);
    chk("overrun_before", 32'(bus.overrun), 32'h0);

    // Byte arriving during BUS is dropped and flags overrun
    bus_q.push_back('{addr: 32'h0000_0300, wdata: 32'h1122_3344, wstrb: 4'hF,
                      rdata: 32'h0, ready_at: 5, vlen: 6});
    push_tx(1, 32'h4B00_0000);
    send_cmd(8'h57, 32'h0000_0300, 32'h1122_3344);
    chk("overrun_in_bus", 32'(bus.mem_valid), 32'h1);
    send_byte(8'h52);
    wait_idle("overrun");
    chk("overrun_set", 32'(bus.overrun), 32'h1);
    check_drained("overrun");

    // Reset in the middle of a bus request
    bus_q.push_back('{addr: 32'h0000_0200, wdata: 32'h0, wstrb: 4'h0,
                      rdata: 32'h0, ready_at: -1, vlen: 0});
    send_cmd(8'h52, 32'h0000_0200, 32'h0);
    repeat (3) @(negedge clk);
    chk("pre_reset_mem_valid", 32'(bus.mem_valid), 32'h1);
    #2;
    rst_i = 1'b1;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    rst_i = 1'b0;
    n = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.tx_valid || bus.mem_valid) n++;
    end
    chk("post_reset_quiet", 32'(n), 32'h0);
    check_drained("midreset");

    bus_q.push_back('{addr: 32'h0000_0040, wdata: 32'h0, wstrb: 4'h0,
                      rdata: 32'hCAFE_F00D, ready_at: 1, vlen: 2});
    push_tx(4, 32'hCAFE_F00D);
    send_cmd(8'h52, 32'h0000_0040, 32'h0);
    wait_idle("after_reset");
    check_drained("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
